// File: rtl/ray_march_pkg.sv
// State encoding and default tuning constants for the ray-march controller.
package ray_march_pkg;

    typedef enum logic [2:0] {
        MS_IDLE   = 3'd0,
        MS_CALC   = 3'd1,
        MS_ISSUE  = 3'd2,
        MS_WAIT   = 3'd3,
        MS_UPDATE = 3'd4,
        MS_DONE   = 3'd5
    } march_state_t;

    localparam int          DEF_MAX_STEPS = 64;
    localparam logic [31:0] DEF_HIT_EPS   = 32'h0000_0419;
    localparam logic [31:0] DEF_MAX_DIST  = 32'h00A0_0000;
    localparam int          DEF_TIMEOUT   = 256;
    localparam logic [31:0] FP_SAT_MAX    = 32'h7FFF_FFFF;

endpackage

// File: rtl/vec_pkg.sv
// Shared fixed-point vector types: fp is signed Q12.20, vec3 packs {z, y, x} with x in the low word.
package vec_pkg;

    localparam int FP_FRAC_BITS = 20;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp z;
        fp y;
        fp x;
    } vec3;

    // Full 64-bit signed product, rescaled back to Q12.20 by dropping the low fraction bits.
    function automatic fp fp_mul(input fp a, input fp b);
        logic signed [63:0] prod;
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return prod[FP_FRAC_BITS +: 32];
    endfunction

endpackage

// File: rtl/vec3_scale_add.sv
// One registered stage computing origin + t*dir per component (Q12.20); cleared on a new ray.
module vec3_scale_add
    import vec_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [95:0] origin_i,
    input  logic [95:0] dir_i,
    input  logic [31:0] t_i,
    output logic [95:0] pos_o
);

    vec3 origin_v;
    vec3 dir_v;
    vec3 pos_d;
    vec3 pos_q;

    assign origin_v = vec3'(origin_i);
    assign dir_v    = vec3'(dir_i);

    always_comb begin
        pos_d   = pos_q;
        pos_d.x = origin_v.x + fp_mul(fp'(t_i), dir_v.x);
        pos_d.y = origin_v.y + fp_mul(fp'(t_i), dir_v.y);
        pos_d.z = origin_v.z + fp_mul(fp'(t_i), dir_v.z);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            pos_q <= '0;
        end else if (en_i) begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ray_march_controller.sv
// Sphere-tracing ray marcher driving the scene-query port; one ray at a time.
// Define RAY_MARCH_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.
module ray_march_controller
    import vec_pkg::*;
    import ray_march_pkg::*;
#(
    parameter int          MAX_STEPS = DEF_MAX_STEPS,
    parameter logic [31:0] HIT_EPS   = DEF_HIT_EPS,
    parameter logic [31:0] MAX_DIST  = DEF_MAX_DIST,
    parameter int          TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [95:0] ray_origin,
    input  logic [95:0] ray_dir,
    input  logic        obj_sel_in,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [95:0] hit_pos,
    output logic [31:0] hit_dist,
    output logic [7:0]  step_count,
    output logic        timeout,
    output logic        query_valid,
    output logic [95:0] query_pos,
    output logic        query_obj_sel,
    input  logic [31:0] query_dist,
    input  logic        query_dist_valid,
    output logic [2:0]  dbg_state_o
);

    localparam logic [2:0] ST_IDLE   = MS_IDLE;
    localparam logic [2:0] ST_CALC   = MS_CALC;
    localparam logic [2:0] ST_ISSUE  = MS_ISSUE;
    localparam logic [2:0] ST_WAIT   = MS_WAIT;
    localparam logic [2:0] ST_UPDATE = MS_UPDATE;
    localparam logic [2:0] ST_DONE   = MS_DONE;

    logic [2:0]  state_q,   state_d;
    logic [95:0] origin_q,  origin_d;
    logic [95:0] dir_q,     dir_d;
    logic        obj_sel_q, obj_sel_d;
    logic [31:0] t_q,       t_d;
    logic [7:0]  steps_q,   steps_d;
    logic [31:0] dist_q,    dist_d;
    logic        hit_q,     hit_d;
    logic        timeout_q, timeout_d;
    logic        wait_expired;
    logic        accept;
    logic [95:0] pos;

    // t >= 0 and d >= HIT_EPS whenever this sum is used, so only positive overflow can occur.
    logic signed [32:0] t_sum;
    logic [31:0]        t_next;
    assign t_sum  = $signed({t_q[31], t_q}) + $signed({dist_q[31], dist_q});
    assign t_next = (t_sum > $signed({1'b0, FP_SAT_MAX})) ? FP_SAT_MAX : t_sum[31:0];

    assign accept = (state_q == ST_IDLE) && start;

`ifdef RAY_MARCH_TIMEOUT_EN
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign wait_expired = (wait_cnt_q == 32'(TIMEOUT - 1));
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        origin_d  = origin_q;
        dir_d     = dir_q;
        obj_sel_d = obj_sel_q;
        t_d       = t_q;
        steps_d   = steps_q;
        dist_d    = dist_q;
        hit_d     = hit_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    origin_d  = ray_origin;
                    dir_d     = ray_dir;
                    obj_sel_d = obj_sel_in;
                    t_d       = '0;
                    steps_d   = '0;
                    hit_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC:  state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (query_dist_valid) begin
                    dist_d  = query_dist;
                    state_d = ST_UPDATE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    hit_d     = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_UPDATE: begin
                steps_d = steps_q + 8'd1;
                if ($signed(dist_q) < $signed(HIT_EPS)) begin
                    hit_d   = 1'b1;
                    state_d = ST_DONE;
                end else if ($signed(t_next) > $signed(MAX_DIST)) begin
                    hit_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (steps_d == 8'(MAX_STEPS)) begin
                    hit_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    t_d     = t_next;
                    state_d = ST_CALC;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            origin_q  <= '0;
            dir_q     <= '0;
            obj_sel_q <= 1'b0;
            t_q       <= '0;
            steps_q   <= '0;
            dist_q    <= '0;
            hit_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            origin_q  <= origin_d;
            dir_q     <= dir_d;
            obj_sel_q <= obj_sel_d;
            t_q       <= t_d;
            steps_q   <= steps_d;
            dist_q    <= dist_d;
            hit_q     <= hit_d;
            timeout_q <= timeout_d;
        end
    end

    vec3_scale_add u_scale_add (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (accept),
        .en_i     (state_q == ST_CALC),
        .origin_i (origin_q),
        .dir_i    (dir_q),
        .t_i      (t_q),
        .pos_o    (pos)
    );

    // t is frozen at termination, so it doubles as the reported ray parameter.
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign query_valid   = (state_q == ST_ISSUE);
    assign query_pos     = pos;
    assign query_obj_sel = obj_sel_q;
    assign hit           = hit_q;
    assign hit_pos       = pos;
    assign hit_dist      = t_q;
    assign step_count    = steps_q;
    assign timeout       = timeout_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ray_march_controller.sv
// Randomized bench for ray_march_controller against a plain-arithmetic sphere-tracing model.
module tb_ray_march_controller;

    localparam int          TO_CYC    = 16;
    localparam int          CAP_STEPS = 4;
    localparam int          MAIN_STEPS = 64;
    localparam logic [31:0] EPS       = 32'h0000_0419;
    localparam logic [31:0] FAR       = 32'h00A0_0000;
    localparam int          BUDGET    = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [95:0] ray_origin = '0;
    logic [95:0] ray_dir = '0;
    logic        obj_sel_in = 1'b0;
    logic [31:0] query_dist = '0;
    logic        query_dist_valid = 1'b0;

    logic        busy_a, done_a, hit_a, timeout_a, qv_a, qobj_a;
    logic        busy_b, done_b, hit_b, timeout_b, qv_b, qobj_b;
    logic [95:0] hpos_a, qpos_a, hpos_b, qpos_b;
    logic [31:0] hdist_a, hdist_b;
    logic [7:0]  steps_a, steps_b;
    logic [2:0]  dbg_a, dbg_b;

    ray_march_controller #(.TIMEOUT(TO_CYC)) dut (
        .clk(clk), .rst(rst), .start(start & ~sel), .ray_origin(ray_origin), .ray_dir(ray_dir),
        .obj_sel_in(obj_sel_in), .busy(busy_a), .done(done_a), .hit(hit_a), .hit_pos(hpos_a),
        .hit_dist(hdist_a), .step_count(steps_a), .timeout(timeout_a), .query_valid(qv_a),
        .query_pos(qpos_a), .query_obj_sel(qobj_a), .query_dist(query_dist),
        .query_dist_valid(query_dist_valid), .dbg_state_o(dbg_a)
    );

    ray_march_controller #(.MAX_STEPS(CAP_STEPS), .TIMEOUT(TO_CYC)) dut_cap (
        .clk(clk), .rst(rst), .start(start & sel), .ray_origin(ray_origin), .ray_dir(ray_dir),
        .obj_sel_in(obj_sel_in), .busy(busy_b), .done(done_b), .hit(hit_b), .hit_pos(hpos_b),
        .hit_dist(hdist_b), .step_count(steps_b), .timeout(timeout_b), .query_valid(qv_b),
        .query_pos(qpos_b), .query_obj_sel(qobj_b), .query_dist(query_dist),
        .query_dist_valid(query_dist_valid), .dbg_state_o(dbg_b)
    );

    logic        busy, done, hit, timeout, query_valid, query_obj_sel;
    logic [95:0] hit_pos, query_pos;
    logic [31:0] hit_dist;
    logic [7:0]  step_count;
    assign busy          = sel ? busy_b    : busy_a;
    assign done          = sel ? done_b    : done_a;
    assign hit           = sel ? hit_b     : hit_a;
    assign timeout       = sel ? timeout_b : timeout_a;
    assign query_valid   = sel ? qv_b      : qv_a;
    assign query_obj_sel = sel ? qobj_b    : qobj_a;
    assign hit_pos       = sel ? hpos_b    : hpos_a;
    assign query_pos     = sel ? qpos_b    : qpos_a;
    assign hit_dist      = sel ? hdist_b   : hdist_a;
    assign step_count    = sel ? steps_b   : steps_a;

    // Scoreboard: expected sample points in issue order.
    logic [95:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          rsp_mode = 0;     // 0 sphere r=0.1 at origin, 1 constant distance, 2 silent
    logic [31:0] rsp_const = '0;
    int          rsp_lat = 1;
    logic        exp_obj = 1'b0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_fx(input real r);
        return 32'($rtoi(r * 1048576.0));
    endfunction

    function automatic real to_r(input logic [31:0] v);
        return $itor($signed(v)) / 1048576.0;
    endfunction

    function automatic logic [31:0] scene(input logic [95:0] p);
        real x, y, z;
        if (rsp_mode != 0) return rsp_const;
        x = to_r(p[31:0]);
        y = to_r(p[63:32]);
        z = to_r(p[95:64]);
        return to_fx($sqrt(x * x + y * y + z * z) - 0.1);
    endfunction

    function automatic logic [95:0] unit_dir(input real x, input real y, input real z);
        real n;
        n = $sqrt(x * x + y * y + z * z);
        if (n < 1.0e-6) return {to_fx(1.0), 32'd0, 32'd0};
        return {to_fx(z / n), to_fx(y / n), to_fx(x / n)};
    endfunction

    // Sphere tracing straight from the rules: sample, step count, hit / far / cap, advance t.
    task automatic model_ray(input logic [95:0] o, input logic [95:0] dv, input int cap,
                             output logic e_hit, output logic [7:0] e_steps,
                             output logic [31:0] e_t, output logic [95:0] e_pos);
        longint      t, s;
        int          n;
        logic [95:0] p;
        logic [31:0] dd;
        logic        fin;
        t = 0; n = 0; e_hit = 1'b0; fin = 1'b0; p = '0;
        while (!fin) begin
            for (int c = 0; c < 3; c++)
                p[c*32 +: 32] = o[c*32 +: 32] + 32'((t * longint'($signed(dv[c*32 +: 32]))) >>> 20);
            exp_q.push_back(p);
            dd = scene(p);
            n++;
            s = t + longint'($signed(dd));
            if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
            if ($signed(dd) < $signed(EPS)) begin
                e_hit = 1'b1; fin = 1'b1;
            end else if (s > longint'(FAR) || n == cap) begin
                fin = 1'b1;
            end else begin
                t = s;
            end
        end
        e_steps = 8'(n);
        e_t = 32'(t);
        e_pos = p;
    endtask

    // Mock scene evaluator: answers each query after rsp_lat cycles.
    initial begin
        logic [31:0] d;
        forever begin
            @(posedge clk); #1;
            if (query_valid && !rst) begin
                if (exp_q.size() == 0) check("query_extra", 96'(1), 96'(0));
                else check("query_pos", query_pos, exp_q.pop_front());
                check("query_obj_sel", 96'(query_obj_sel), 96'(exp_obj));
                if (rsp_mode != 2) begin
                    d = scene(query_pos);
                    repeat (rsp_lat) @(posedge clk);
                    #1;
                    query_dist = d;
                    query_dist_valid = 1'b1;
                    @(posedge clk); #1;
                    query_dist_valid = 1'b0;
                    query_dist = $urandom;
                end
            end
        end
    end

    task automatic launch(input logic s, input logic [95:0] o, input logic [95:0] dv, input logic ob);
        int guard;
        guard = 0;
        while (busy && guard < BUDGET) begin
            @(posedge clk); #1;
            guard++;
        end
        sel = s;
        @(posedge clk); #1;
        ray_origin = o; ray_dir = dv; obj_sel_in = ob; exp_obj = ob;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 96'(busy), 96'(1));
    endtask

    task automatic run_ray(input string tag, input logic s, input int mode, input logic [31:0] cval,
                           input logic [95:0] o, input logic [95:0] dv, input logic ob,
                           input int lat, input logic junk);
        logic        e_hit;
        logic [7:0]  e_steps;
        logic [31:0] e_t;
        logic [95:0] e_pos;
        int          cyc;
        rsp_mode = mode; rsp_const = cval; rsp_lat = lat;
        exp_q.delete();
        model_ray(o, dv, s ? CAP_STEPS : MAIN_STEPS, e_hit, e_steps, e_t, e_pos);
        launch(s, o, dv, ob);
        cyc = 1;
        while (!done && cyc < BUDGET) begin
            if (junk) begin
                start = 1'($urandom_range(0, 1));
                ray_origin = {$urandom, $urandom, $urandom};
                obj_sel_in = ~ob;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            check({tag, "_done_wait"}, 96'(0), 96'(1));
        end else begin
            check({tag, "_done_cycle"}, 96'(cyc), 96'(int'(e_steps) * (lat + 3) + 1));
            check({tag, "_hit"}, 96'(hit), 96'(e_hit));
            check({tag, "_steps"}, 96'(step_count), 96'(e_steps));
            check({tag, "_hit_dist"}, 96'(hit_dist), 96'(e_t));
            check({tag, "_hit_pos"}, hit_pos, e_pos);
            check({tag, "_timeout"}, 96'(timeout), 96'(0));
        end
        check({tag, "_all_queried"}, 96'(exp_q.size()), 96'(0));
        @(posedge clk); #1;
        check({tag, "_single_done"}, 96'(done), 96'(0));
        check({tag, "_busy_fall"}, 96'(busy), 96'(0));
        check({tag, "_hit_hold"}, 96'(hit), 96'(e_hit));
    endtask

    function automatic logic [31:0] rnd_coord();
        return to_fx(($itor($urandom_range(0, 6000)) - 3000.0) / 1000.0);
    endfunction

    function automatic real rnd_unit();
        return ($itor($urandom_range(0, 2000)) - 1000.0) / 1000.0;
    endfunction

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return ($signed(a) > $signed(b)) ? a - b : b - a;
    endfunction

    initial begin
        logic [95:0] o, dv;
        int nd, cyc;
        real ox, oy, oz;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags_a", 96'({busy_a, done_a, hit_a, timeout_a, qv_a, qobj_a}), 96'(0));
        check("rst_data_a", {hpos_a ^ qpos_a, hdist_a, steps_a} == '0 ? 96'(0) : 96'(1), 96'(0));
        check("rst_flags_b", 96'({busy_b, done_b, hit_b, timeout_b, qv_b, qobj_b}), 96'(0));
        rst = 1'b0;

        // Sphere hit along +z
        run_ray("sphere_hit", 1'b0, 0, 32'd0, {to_fx(-1.0), 32'd0, 32'd0}, {to_fx(1.0), 32'd0, 32'd0},
                1'b1, 2, 1'b0);
        check("sphere_hit_dist_ref", 96'(abs_diff(hit_dist, 32'h000E_6666) <= 1), 96'(1));
        check("sphere_hit_steps_ref", 96'(step_count), 96'(2));

        // Sphere miss, offset by 1.0 in x
        run_ray("sphere_miss", 1'b0, 0, 32'd0, {to_fx(-1.0), 32'd0, to_fx(1.0)},
                {to_fx(1.0), 32'd0, 32'd0}, 1'b0, 1, 1'b0);
        check("sphere_miss_hit_ref", 96'(hit), 96'(0));
        check("sphere_miss_under_cap", 96'(step_count < 8'd64), 96'(1));

        // Step cap on the MAX_STEPS=4 instance, constant 0.01 responses
        run_ray("step_cap", 1'b1, 1, to_fx(0.01), {to_fx(-1.0), 32'd0, 32'd0},
                {to_fx(1.0), 32'd0, 32'd0}, 1'b0, 3, 1'b0);
        check("step_cap_steps_ref", 96'(step_count), 96'(4));
        check("step_cap_dist_ref", 96'(abs_diff(hit_dist, 32'h0000_7AE1) <= 2), 96'(1));

        // Negative distance on the first query
        run_ray("neg_dist", 1'b0, 1, 32'hFFF0_0000, {32'd0, to_fx(0.5), 32'd0},
                {32'd0, to_fx(1.0), 32'd0}, 1'b1, 1, 1'b0);
        check("neg_dist_ref", 96'({hit, step_count, hit_dist}), 96'({1'b1, 8'd1, 32'd0}));

        // start pulses while busy must be ignored
        run_ray("busy_ignore", 1'b0, 0, 32'd0, {to_fx(-2.0), to_fx(0.05), 32'd0},
                unit_dir(0.0, -0.02, 1.0), 1'b1, 2, 1'b1);

        // Reset while waiting for a response: no done, everything back to zero
        rsp_mode = 2; rsp_lat = 1; exp_q.delete();
        o = {to_fx(-1.0), to_fx(0.25), to_fx(0.5)};
        exp_q.push_back(o);
        launch(1'b0, o, {to_fx(1.0), 32'd0, 32'd0}, 1'b1);
        nd = 0;
        repeat (5) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_wait_no_done", 96'(nd), 96'(0));
        check("rst_wait_flags", 96'({busy, done, hit, timeout, query_valid, query_obj_sel}), 96'(0));
        check("rst_wait_pos", hit_pos, 96'(0));
        check("rst_wait_steps", 96'({step_count, hit_dist}), 96'(0));
        check("rst_wait_queried", 96'(exp_q.size()), 96'(0));
        run_ray("after_rst", 1'b0, 0, 32'd0, {to_fx(-1.0), 32'd0, 32'd0}, {to_fx(1.0), 32'd0, 32'd0},
                1'b0, 1, 1'b0);

`ifdef RAY_MARCH_TIMEOUT_EN
        // Silent evaluator: WAIT entered at cycle 3, gives up TIMEOUT cycles later
        rsp_mode = 2; exp_q.delete();
        o = {to_fx(0.75), to_fx(-0.5), to_fx(0.25)};
        exp_q.push_back(o);
        launch(1'b0, o, {to_fx(1.0), 32'd0, 32'd0}, 1'b0);
        cyc = 1;
        while (!done && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("timeout_cycle", 96'(cyc), 96'(3 + TO_CYC));
        check("timeout_flag", 96'({timeout, hit, step_count, hit_dist}), 96'({1'b1, 1'b0, 8'd0, 32'd0}));
        check("timeout_pos", hit_pos, o);
        @(posedge clk); #1;
        check("timeout_busy_fall", 96'(busy), 96'(0));
`endif

        // Randomized rays: sphere on the main instance, constant distances on the capped one
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_ray("rand_const", 1'b1, 1, 32'($urandom_range(0, 32'h0018_0000)) - 32'h0002_0000,
                        {rnd_coord(), rnd_coord(), rnd_coord()}, unit_dir(rnd_unit(), rnd_unit(), rnd_unit()),
                        1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end else begin
                o = {rnd_coord(), rnd_coord(), rnd_coord()};
                ox = to_r(o[31:0]); oy = to_r(o[63:32]); oz = to_r(o[95:64]);
                if ($urandom_range(0, 1) == 0)
                    dv = unit_dir(-ox + 0.02 * rnd_unit(), -oy + 0.02 * rnd_unit(), -oz + 0.02 * rnd_unit());
                else
                    dv = unit_dir(rnd_unit(), rnd_unit(), rnd_unit());
                run_ray("rand_sphere", 1'b0, 0, 32'd0, o, dv, 1'($urandom_range(0, 1)),
                        $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
